// File: rtl/dino_frame_scanner.sv
// Frame timer plus raster scanner: requests one pixel per cycle from the renderer
// and plots its colour READ_LATENCY cycles later through a matching valid/x/y shift line.
module dino_frame_scanner #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int READ_LATENCY = 2,
  parameter int FRAME_TICKS  = 833334
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] x,
  output logic [7:0] y,
  input  logic [2:0] color_in,
  output logic       frameClk,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       frame_done,
  output logic       overrun
);

  localparam int CW = $clog2(FRAME_TICKS);
  localparam int DW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(FRAME_TICKS / 2);
  localparam logic [7:0]    X_LAST     = 8'(SCREEN_W - 1);
  localparam logic [7:0]    Y_LAST     = 8'(SCREEN_H - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  frame_cnt_q, frame_cnt_d;
  logic [7:0]                     x_q, x_d, y_q, y_d;
  logic [DW-1:0]                  drain_q, drain_d;
  logic                           overrun_q, overrun_d;
  logic [READ_LATENCY-1:0]        pv_q, pv_d;
  logic [READ_LATENCY-1:0][7:0]   px_q, px_d, py_q, py_d;
  logic                           tick;

  assign tick = (frame_cnt_q == CNT_LAST);

  always_comb begin
    frame_cnt_d = tick ? '0 : frame_cnt_q + CW'(1);
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    drain_d     = drain_q;
    // A tick outside IDLE is dropped rather than restarting the scan.
    overrun_d   = overrun_q | (tick && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = IDLE;
        else                       drain_d = drain_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    pv_d    = pv_q;
    px_d    = px_q;
    py_d    = py_q;
    pv_d[0] = (state_q == SCAN);
    px_d[0] = x_q;
    py_d[0] = y_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      px_d[i] = px_q[i-1];
      py_d[i] = py_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      drain_q     <= '0;
      overrun_q   <= 1'b0;
      pv_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_q     <= drain_d;
      overrun_q   <= overrun_d;
      pv_q        <= pv_d;
      px_q        <= px_d;
      py_q        <= py_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign frameClk   = (frame_cnt_q >= CNT_HALF);
  assign vga_plot   = pv_q[READ_LATENCY-1];
  assign vga_x      = px_q[READ_LATENCY-1];
  assign vga_y      = py_q[READ_LATENCY-1];
  assign vga_color  = vga_plot ? color_in : 3'd0;
  assign frame_done = vga_plot && (vga_x == X_LAST) && (vga_y == Y_LAST);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dino_frame_scanner.sv
// Directed bench: dut_a (FRAME_TICKS=20) for timing, enable and reset cases;
// dut_b (FRAME_TICKS=12) for overrun. Screen is 4x3, read latency 2.
module tb_dino_frame_scanner;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1, enable_a = 1'b1;
  logic       reset_b = 1'b1, enable_b = 1'b1;
  logic [7:0] x_a, y_a, vx_a, vy_a, x_b, y_b, vx_b, vy_b;
  logic [2:0] col_a, col_b, vc_a, vc_b;
  logic       fclk_a, plot_a, done_a, ovr_a, fclk_b, plot_b, done_b, ovr_b;
  logic [7:0] xa_d1, xa_d2, xb_d1, xb_d2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Renderer stand-in: colour is the requested x, two cycles late.
  always @(posedge clk) begin
    xa_d1 <= x_a; xa_d2 <= xa_d1;
    xb_d1 <= x_b; xb_d2 <= xb_d1;
  end
  assign col_a = xa_d2[2:0];
  assign col_b = xb_d2[2:0];

  dino_frame_scanner #(.SCREEN_W(4), .SCREEN_H(3), .READ_LATENCY(2), .FRAME_TICKS(20)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .x(x_a), .y(y_a), .color_in(col_a),
    .frameClk(fclk_a), .vga_x(vx_a), .vga_y(vy_a), .vga_color(vc_a), .vga_plot(plot_a),
    .frame_done(done_a), .overrun(ovr_a));

  dino_frame_scanner #(.SCREEN_W(4), .SCREEN_H(3), .READ_LATENCY(2), .FRAME_TICKS(12)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .x(x_b), .y(y_b), .color_in(col_b),
    .frameClk(fclk_b), .vga_x(vx_b), .vga_y(vy_b), .vga_color(vc_b), .vga_plot(plot_b),
    .frame_done(done_b), .overrun(ovr_b));

  typedef struct {
    int         cyc;
    logic       fclk;
    logic [7:0] x;
    logic [7:0] y;
    logic       chk_xy;
    logic       plot;
    logic [7:0] vx;
    logic [7:0] vy;
    logic       done;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Releases reset_a just after a clock edge; the caller's next negedge is cycle 0.
  task automatic reset_dut_a(input logic en);
    enable_a = en;
    reset_a  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0;
  endtask

  task automatic run_frame_check(input string tag);
    int k = 0;
    int nplots = 0;
    int ndone = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      if (k < 13 && tbl[k].cyc == c) begin
        chk($sformatf("%s.c%0d.frameClk", tag, c), 32'(fclk_a), 32'(tbl[k].fclk));
        chk($sformatf("%s.c%0d.plot", tag, c), 32'(plot_a), 32'(tbl[k].plot));
        chk($sformatf("%s.c%0d.done", tag, c), 32'(done_a), 32'(tbl[k].done));
        if (tbl[k].chk_xy) begin
          chk($sformatf("%s.c%0d.x", tag, c), 32'(x_a), 32'(tbl[k].x));
          chk($sformatf("%s.c%0d.y", tag, c), 32'(y_a), 32'(tbl[k].y));
        end
        if (tbl[k].plot || c == 0) begin
          chk($sformatf("%s.c%0d.vga_x", tag, c), 32'(vx_a), 32'(tbl[k].vx));
          chk($sformatf("%s.c%0d.vga_y", tag, c), 32'(vy_a), 32'(tbl[k].vy));
        end
        k++;
      end
      if (plot_a) begin
        if (first < 0) first = c;
        last = c;
        chk($sformatf("%s.raster_x%0d", tag, nplots), 32'(vx_a), 32'(nplots % 4));
        chk($sformatf("%s.raster_y%0d", tag, nplots), 32'(vy_a), 32'(nplots / 4));
        chk($sformatf("%s.color%0d", tag, nplots), 32'(vc_a), 32'(nplots % 4));
        nplots++;
      end
      if (done_a) ndone++;
    end
    chk({tag, ".plot_count"}, 32'(nplots), 32'd12);
    chk({tag, ".first_plot"}, 32'(first), 32'd22);
    chk({tag, ".last_plot"}, 32'(last), 32'd33);
    chk({tag, ".done_count"}, 32'(ndone), 32'd1);
    chk({tag, ".overrun"}, 32'(ovr_a), 32'd0);
  endtask

  initial begin
    //          cyc fclk x     y     chkxy plot  vx    vy    done
    tbl[0]  = '{0,  1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[1]  = '{9,  1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[2]  = '{10, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[3]  = '{19, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[4]  = '{20, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[5]  = '{21, 1'b0, 8'd1, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[6]  = '{22, 1'b0, 8'd2, 8'd0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0};
    tbl[7]  = '{24, 1'b0, 8'd0, 8'd1, 1'b1, 1'b1, 8'd2, 8'd0, 1'b0};
    tbl[8]  = '{31, 1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 8'd1, 8'd2, 1'b0};
    tbl[9]  = '{32, 1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0};
    tbl[10] = '{33, 1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 8'd3, 8'd2, 1'b1};
    tbl[11] = '{34, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[12] = '{40, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};

    // Basic timing, raster order, colour passthrough.
    reset_dut_a(1'b1);
    run_frame_check("scan");

    // Reset on the fifth plot, then the same timing from scratch.
    reset_dut_a(1'b1);
    repeat (27) @(negedge clk);
    chk("rst.plot5", 32'(plot_a), 32'd1);
    chk("rst.plot5_x", 32'(vx_a), 32'd0);
    chk("rst.plot5_y", 32'(vy_a), 32'd1);
    reset_a = 1'b1;
    @(negedge clk);
    chk("rst.plot", 32'(plot_a), 32'd0);
    chk("rst.x", 32'(x_a), 32'd0);
    chk("rst.y", 32'(y_a), 32'd0);
    chk("rst.vga_x", 32'(vx_a), 32'd0);
    chk("rst.vga_y", 32'(vy_a), 32'd0);
    chk("rst.color", 32'(vc_a), 32'd0);
    chk("rst.frameClk", 32'(fclk_a), 32'd0);
    chk("rst.done", 32'(done_a), 32'd0);
    @(posedge clk);
    #1 reset_a = 1'b0;
    run_frame_check("rescan");

    // Enable held low for three frames, raised mid-frame, dropped mid-scan.
    begin
      int nplots = 0;
      int early = 0;
      int ndone = 0;
      int first = -1;
      reset_dut_a(1'b0);
      for (int c = 0; c <= 130; c++) begin
        @(negedge clk);
        if (plot_a) begin
          if (c < 60) early++;
          if (first < 0) first = c;
          nplots++;
        end
        if (done_a) ndone++;
        if (c == 80) begin
          chk("en.x_start", 32'(x_a), 32'd0);
          chk("en.y_start", 32'(y_a), 32'd0);
        end
        if (c == 81) chk("en.x_second", 32'(x_a), 32'd1);
        if (c == 65) enable_a = 1'b1;
        if (c == 85) enable_a = 1'b0;
      end
      chk("en.no_plots_disabled", 32'(early), 32'd0);
      chk("en.first_plot", 32'(first), 32'd82);
      chk("en.plot_count", 32'(nplots), 32'd12);
      chk("en.done_count", 32'(ndone), 32'd1);
      chk("en.overrun", 32'(ovr_a), 32'd0);
    end

    // Short frame period: tick lands during the scan.
    begin
      int n1 = 0;
      int first1 = -1;
      int first2 = -1;
      int last1 = -1;
      int idx = 0;
      @(posedge clk);
      #1 reset_b = 1'b0;
      for (int c = 0; c <= 50; c++) begin
        @(negedge clk);
        if (c == 0) chk("ovr.reset", 32'(ovr_b), 32'd0);
        if (c == 23) chk("ovr.before_tick", 32'(ovr_b), 32'd0);
        if (c == 24) chk("ovr.after_tick", 32'(ovr_b), 32'd1);
        if (c == 25) chk("ovr.done_last", 32'(done_b), 32'd1);
        if (plot_b) begin
          chk($sformatf("ovr.raster_x%0d", idx), 32'(vx_b), 32'(idx % 4));
          chk($sformatf("ovr.raster_y%0d", idx), 32'(vy_b), 32'(idx / 4));
          chk($sformatf("ovr.color%0d", idx), 32'(vc_b), 32'(idx % 4));
          idx = (idx + 1) % 12;
          if (c <= 37) begin
            n1++;
            if (first1 < 0) first1 = c;
            last1 = c;
          end else if (first2 < 0) begin
            first2 = c;
          end
        end
      end
      chk("ovr.frame1_plots", 32'(n1), 32'd12);
      chk("ovr.frame1_first", 32'(first1), 32'd14);
      chk("ovr.frame1_last", 32'(last1), 32'd25);
      chk("ovr.frame2_first", 32'(first2), 32'd38);
      chk("ovr.sticky", 32'(ovr_b), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
